// File: rtl/intexp_prio.sv
// intexp_prio
//   Interrupt/exception controller. It arbitrates NUM_IRQ maskable interrupt
//   lines and four memory exceptions by fixed priority, then computes the IDT
//   entry address and captures the precise CS:EIP. It drains the pipeline and
//   then drives the microsequencer ROM through an entry or IRET sequence of
//   2**RSEQ_AW micro-ops. While an IRQ handler is in service, no further IRQ
//   is taken. An exception that arrives while the FSM is busy raises a sticky
//   double-fault flag.
//
// Ports
//   clk, rst                     clock, asynchronous active-high reset
//   irq, irq_mask                level requests / per-line mask (1 = masked)
//   dc_prot_exp, dc_page_fault   data-side exception strobes (RO-stage EIP)
//   ic_prot_exp, ic_page_fault   fetch-side exception strobes (decode EIP)
//   end_bit, iret_op             instruction boundary, IRET decoded
//   pipe_valid, fifo_empty_bar   drain conditions
//   ld_ag                        AG accepted the current micro-op
//   eip_reg/cs_reg               decode-stage return point
//   eip_ro_reg/cs_ro_reg         RO-stage return point
//   idt_addr                     selected IDT entry address
//   eip_saved/cs_saved           captured return point
//   rseq_addr                    {iret_mode, step}
//   rseq_mux_sel, block_ic_ren   ROM source select, I-cache read stall
//   irq_ack                      one-hot, one-cycle acknowledge pulse
//   in_service, dbl_fault, busy  status
module intexp_prio #(
    parameter int unsigned NUM_IRQ    = 4,
    parameter int unsigned NUM_STG    = 5,
    parameter logic [31:0] IDT_BASE   = 32'h0000_2000,
    parameter int unsigned VEC_STRIDE = 8,
    parameter int unsigned IRQ_VEC0   = 2,
    parameter int unsigned RSEQ_AW    = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_IRQ-1:0]   irq,
    input  logic [NUM_IRQ-1:0]   irq_mask,
    input  logic                 dc_prot_exp,
    input  logic                 dc_page_fault,
    input  logic                 ic_prot_exp,
    input  logic                 ic_page_fault,
    input  logic                 end_bit,
    input  logic                 iret_op,
    input  logic [NUM_STG-1:0]   pipe_valid,
    input  logic                 fifo_empty_bar,
    input  logic                 ld_ag,
    input  logic [31:0]          eip_reg,
    input  logic [15:0]          cs_reg,
    input  logic [31:0]          eip_ro_reg,
    input  logic [15:0]          cs_ro_reg,
    output logic [31:0]          idt_addr,
    output logic [31:0]          eip_saved,
    output logic [15:0]          cs_saved,
    output logic [RSEQ_AW:0]     rseq_addr,
    output logic                 rseq_mux_sel,
    output logic                 block_ic_ren,
    output logic [NUM_IRQ-1:0]   irq_ack,
    output logic                 in_service,
    output logic                 dbl_fault,
    output logic                 busy
);

    localparam int unsigned IDX_W = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        RSEQ  = 2'd2
    } state_t;

    state_t               state;
    logic                 mode;
    logic                 irq_entry;
    logic [RSEQ_AW-1:0]   step;
    logic [IDX_W-1:0]     irq_idx;

    logic                 exc_any;
    logic                 exc_use_ro;
    logic [31:0]          exc_vec;
    logic [31:0]          exc_addr;
    logic [NUM_IRQ-1:0]   irq_pend;
    logic                 irq_any;
    logic [IDX_W-1:0]     win_idx;
    logic [31:0]          irq_addr;
    logic                 drained;

    assign exc_any  = dc_prot_exp | dc_page_fault | ic_prot_exp | ic_page_fault;
    assign irq_pend = irq & ~irq_mask;
    assign irq_any  = |irq_pend;
    assign drained  = (pipe_valid == '0) && !fifo_empty_bar;

    // Exception priority: data-side faults carry the RO-stage return point,
    // because the faulting instruction has already left decode.
    always_comb begin
        exc_vec    = 32'd14;
        exc_use_ro = 1'b0;
        if (dc_prot_exp) begin
            exc_vec    = 32'd13;
            exc_use_ro = 1'b1;
        end else if (dc_page_fault) begin
            exc_vec    = 32'd14;
            exc_use_ro = 1'b1;
        end else if (ic_prot_exp) begin
            exc_vec    = 32'd13;
        end
    end

    // Lowest-index unmasked line wins; scanning downward lets it overwrite.
    always_comb begin
        win_idx = '0;
        for (int i = NUM_IRQ - 1; i >= 0; i--) begin
            if (irq_pend[i]) begin
                win_idx = IDX_W'(i);
            end
        end
    end

    assign exc_addr  = IDT_BASE + exc_vec * VEC_STRIDE;
    assign irq_addr  = IDT_BASE + (IRQ_VEC0 + 32'(win_idx)) * VEC_STRIDE;
    assign rseq_addr = {mode, step};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            mode         <= 1'b0;
            irq_entry    <= 1'b0;
            step         <= '0;
            irq_idx      <= '0;
            idt_addr     <= '0;
            eip_saved    <= '0;
            cs_saved     <= '0;
            rseq_mux_sel <= 1'b0;
            block_ic_ren <= 1'b0;
            irq_ack      <= '0;
            in_service   <= 1'b0;
            dbl_fault    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            irq_ack <= '0;
            case (state)
                IDLE: begin
                    if (exc_any) begin
                        idt_addr     <= exc_addr;
                        eip_saved    <= exc_use_ro ? eip_ro_reg : eip_reg;
                        cs_saved     <= exc_use_ro ? cs_ro_reg : cs_reg;
                        mode         <= 1'b0;
                        irq_entry    <= 1'b0;
                        state        <= DRAIN;
                        busy         <= 1'b1;
                        block_ic_ren <= 1'b1;
                    end else if (irq_any && !in_service && end_bit) begin
                        idt_addr     <= irq_addr;
                        eip_saved    <= eip_reg;
                        cs_saved     <= cs_reg;
                        irq_idx      <= win_idx;
                        mode         <= 1'b0;
                        irq_entry    <= 1'b1;
                        state        <= DRAIN;
                        busy         <= 1'b1;
                        block_ic_ren <= 1'b1;
                    end else if (iret_op && end_bit) begin
                        mode         <= 1'b1;
                        irq_entry    <= 1'b0;
                        state        <= DRAIN;
                        busy         <= 1'b1;
                        block_ic_ren <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (exc_any) begin
                        dbl_fault <= 1'b1;
                    end
                    if (drained) begin
                        state        <= RSEQ;
                        step         <= '0;
                        rseq_mux_sel <= 1'b1;
                    end
                end
                RSEQ: begin
                    if (exc_any) begin
                        dbl_fault <= 1'b1;
                    end
                    if (ld_ag) begin
                        if (step == '1) begin
                            state        <= IDLE;
                            step         <= '0;
                            busy         <= 1'b0;
                            block_ic_ren <= 1'b0;
                            rseq_mux_sel <= 1'b0;
                            if (mode) begin
                                in_service <= 1'b0;
                            end else if (irq_entry) begin
                                irq_ack    <= NUM_IRQ'(1) << irq_idx;
                                in_service <= 1'b1;
                            end
                        end else begin
                            step <= step + 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
